// File: rtl/demux_sched_pkg.sv
// demux_scheduler shared types and constants.
// Transaction bundle captured at handshake; one-hot strobe helper.
package demux_sched_pkg;

  localparam int NUM_DEST = 4;
  localparam int SEL_W    = 2;
  localparam int CNT_W    = 8;
  localparam int HC_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             data;
  } xfer_t;

  function automatic logic [NUM_DEST-1:0] onehot(
    input logic [SEL_W-1:0] s
  );
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/demux_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Searches ptr+1, ptr+2, ptr+3, ptr for the first requester.
module rr_pick
  import demux_sched_pkg::*;
(
  input  logic [NUM_DEST-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any
);

  logic [SEL_W-1:0] idx;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    grant_idx = ptr;
    idx       = '0;
    any       = |req;
    for (int k = NUM_DEST; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) grant_idx = idx;
    end
  end

endmodule

// File: rtl/demux_scheduler.sv
// Setup/strobe/hold sequencer for the 1-to-4 demux and latch bank.
// Define DEMUX_SCHED_STATS_EN to add per-destination delivery counters.
module demux_scheduler
  import demux_sched_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_data,
  output logic                in_ready,
  input  logic                mode,
  input  logic [SEL_W-1:0]    fixed_sel,
  input  logic [NUM_DEST-1:0] dest_ready,
  output logic [SEL_W-1:0]    Sel,
  output logic                demux_in,
  output logic [NUM_DEST-1:0] strobe,
  output logic                busy
`ifdef DEMUX_SCHED_STATS_EN
  ,output logic [NUM_DEST*CNT_W-1:0] deliv_cnt
`endif
);

  state_t              state_q, state_d;
  xfer_t               xfer_q, xfer_d;
  logic [HC_W-1:0]     cnt_q, cnt_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [NUM_DEST-1:0] strobe_q, strobe_d;
  logic                busy_q;
  logic                done;

  logic [SEL_W-1:0]    rr_idx;
  logic                rr_any;
  logic [SEL_W-1:0]    pick_idx;
  logic                eligible;

  rr_pick u_pick (
    .req       (dest_ready),
    .ptr       (ptr_q),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  assign eligible = mode ? dest_ready[fixed_sel] : rr_any;
  assign pick_idx = mode ? fixed_sel : rr_idx;
  assign in_ready = !reset && (state_q == IDLE) && eligible;

  assign Sel      = xfer_q.sel;
  assign demux_in = xfer_q.data;
  assign strobe   = strobe_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      xfer_q   <= '0;
      cnt_q    <= '0;
      ptr_q    <= SEL_W'(NUM_DEST - 1);
      strobe_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      xfer_q   <= xfer_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      strobe_q <= strobe_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          xfer_d.sel  = pick_idx;
          xfer_d.data = in_data;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = HC_W'(HOLD_CYCLES);
        state_d = PULSE;
      end
      PULSE: begin
        if (cnt_q <= HC_W'(1)) state_d = HOLD;
        else cnt_d = cnt_q - HC_W'(1);
      end
      HOLD: begin
        ptr_d   = xfer_q.sel;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    strobe_d = (state_d == PULSE) ? onehot(xfer_q.sel) : '0;
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [CNT_W-1:0] dcnt_q [NUM_DEST];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DEST; i++) dcnt_q[i] <= '0;
    end else if (done) begin
      dcnt_q[xfer_q.sel] <= dcnt_q[xfer_q.sel] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_cnt
    assign deliv_cnt[g*CNT_W +: CNT_W] = dcnt_q[g];
  end
`endif

endmodule

// File: tb/tb_demux_scheduler.sv
// Randomized self-checking bench for demux_scheduler.
// Reference model: last-grant index, latch bank contents, delivery counts.
module tb_demux_scheduler;

  localparam int HC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_data;
  logic       in_ready;
  logic       mode;
  logic [1:0] fixed_sel;
  logic [3:0] dest_ready;
  logic [1:0] Sel;
  logic       demux_in;
  logic [3:0] strobe;
  logic       busy;
`ifdef DEMUX_SCHED_STATS_EN
  logic [31:0] deliv_cnt;
`endif

  demux_scheduler #(.HOLD_CYCLES(HC)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mode       (mode),
    .fixed_sel  (fixed_sel),
    .dest_ready (dest_ready),
    .Sel        (Sel),
    .demux_in   (demux_in),
    .strobe     (strobe),
    .busy       (busy)
`ifdef DEMUX_SCHED_STATS_EN
    ,.deliv_cnt (deliv_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int       last_grant;
  bit [3:0] latch = '0;
  bit [3:0] exp_latch = '0;
  int       exp_cnt [4];

  // Board latch bank: transparent-on-strobe, captured at the clock edge.
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (strobe[i]) latch[i] <= demux_in;

  function automatic int model_pick();
    if (mode) return int'(fixed_sel);
    for (int k = 1; k <= 4; k++)
      if (dest_ready[(last_grant + k) % 4]) return (last_grant + k) % 4;
    return -1;
  endfunction

  function automatic bit model_elig();
    return mode ? dest_ready[fixed_sel] : (dest_ready != 4'b0);
  endfunction

`ifdef DEMUX_SCHED_STATS_EN
  task automatic check_cnt(input string tag);
    logic [31:0] e;
    for (int i = 0; i < 4; i++) e[i*8 +: 8] = 8'(exp_cnt[i]);
    checks++;
    if (deliv_cnt !== e) begin
      failures++;
      $display("FAIL %s deliv_cnt got=%h exp=%h", tag, deliv_cnt, e);
    end
  endtask
`endif

  task automatic model_reset();
    last_grant = 3;
    for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
  endtask

  // One full transaction; optionally disturbs inputs during SETUP.
  task automatic deliver(input bit d, input bit scramble,
                         output logic [1:0] got);
    int es;
    bit ok;
    got = 2'bxx;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL handshake_timeout in_ready=%b exp=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    es = model_pick();
    @(posedge clk);
    @(negedge clk);
    got      = Sel;
    in_valid = 1'b0;
    in_data  = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || Sel !== es[1:0] || demux_in !== d ||
        strobe !== 4'b0) begin
      failures++;
      $display("FAIL setup busy=%b sel=%0d din=%b strobe=%b exp 1/%0d/%b/0000",
               busy, Sel, demux_in, strobe, es, d);
    end
    if (scramble) begin
      dest_ready = 4'($urandom);
      fixed_sel  = 2'($urandom);
      mode       = 1'($urandom);
    end
    for (int k = 1; k <= HC; k++) begin
      @(negedge clk);
      checks++;
      if (strobe !== (4'b0001 << es) || busy !== 1'b1 ||
          in_ready !== 1'b0 || Sel !== es[1:0]) begin
        failures++;
        $display("FAIL pulse%0d strobe=%b busy=%b rdy=%b sel=%0d exp strobe=%b",
                 k, strobe, busy, in_ready, Sel, 4'b0001 << es);
      end
    end
    @(negedge clk);
    checks++;
    if (strobe !== 4'b0 || busy !== 1'b1 || in_ready !== 1'b0 ||
        Sel !== es[1:0] || demux_in !== d) begin
      failures++;
      $display("FAIL hold strobe=%b busy=%b rdy=%b sel=%0d din=%b exp 0000/1/0/%0d/%b",
               strobe, busy, in_ready, Sel, demux_in, es, d);
    end
    @(negedge clk);
    #1;
    last_grant    = es;
    exp_latch[es] = d;
    exp_cnt[es]   = (exp_cnt[es] + 1) % 256;
    checks++;
    if (busy !== 1'b0 || strobe !== 4'b0 || in_ready !== model_elig() ||
        Sel !== es[1:0] || demux_in !== d) begin
      failures++;
      $display("FAIL idle busy=%b strobe=%b rdy=%b sel=%0d din=%b exp 0/0000/%b/%0d/%b",
               busy, strobe, in_ready, Sel, demux_in, model_elig(), es, d);
    end
    checks++;
    if (latch !== exp_latch) begin
      failures++;
      $display("FAIL latch got=%b exp=%b", latch, exp_latch);
    end
`ifdef DEMUX_SCHED_STATS_EN
    check_cnt("deliver");
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset      = 1'b1;
    in_valid   = 1'b1;
    dest_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || Sel !== 2'd0 ||
        demux_in !== 1'b0 || strobe !== 4'b0) begin
      failures++;
      $display("FAIL reset_state rdy=%b busy=%b sel=%0d din=%b strobe=%b exp all 0",
               in_ready, busy, Sel, demux_in, strobe);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
`ifdef DEMUX_SCHED_STATS_EN
    check_cnt("reset");
`endif
  endtask

  task automatic test_rr_all();
    logic [1:0] g;
    bit [4:0] bits = 5'b01101;
    int seq [5] = '{0, 1, 2, 3, 0};
    mode = 1'b0;
    dest_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      deliver(bits[i], 1'b0, g);
      checks++;
      if (g !== 2'(seq[i])) begin
        failures++;
        $display("FAIL rr_all[%0d] sel=%0d exp=%0d", i, g, seq[i]);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] g;
    int seq [3] = '{0, 2, 0};
    mode = 1'b0;
    dest_ready = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      deliver(1'($urandom), 1'b0, g);
      checks++;
      if (g !== 2'(seq[i])) begin
        failures++;
        $display("FAIL rr_sparse[%0d] sel=%0d exp=%0d", i, g, seq[i]);
      end
    end
  endtask

  task automatic test_fixed();
    logic [1:0] g;
    mode = 1'b1;
    fixed_sel = 2'd2;
    dest_ready = 4'b0100;
    deliver(1'b1, 1'b0, g);
    checks++;
    if (g !== 2'd2) begin
      failures++;
      $display("FAIL fixed sel=%0d exp=2", g);
    end
  endtask

  task automatic test_commit();
    logic [1:0] g;
    mode = 1'b1;
    fixed_sel = 2'd1;
    dest_ready = 4'b0010;
    deliver(1'b1, 1'b1, g);
    checks++;
    if (g !== 2'd1) begin
      failures++;
      $display("FAIL commit sel=%0d exp=1", g);
    end
  endtask

  task automatic test_no_dest();
    logic [1:0] g;
    mode = 1'b0;
    dest_ready = 4'b0000;
    in_valid = 1'b1;
    in_data = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || strobe !== 4'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL no_dest[%0d] rdy=%b strobe=%b busy=%b exp 0/0000/0",
                 i, in_ready, strobe, busy);
      end
    end
    dest_ready = 4'b1000;
    deliver(1'b1, 1'b0, g);
    checks++;
    if (g !== 2'd3) begin
      failures++;
      $display("FAIL no_dest_release sel=%0d exp=3", g);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [1:0] g;
    bit ok;
    mode = 1'b1;
    fixed_sel = 2'd1;
    dest_ready = 4'b1111;
    in_data = 1'b1;
    in_valid = 1'b1;
    #1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL abort_handshake_timeout rdy=%b exp=1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (strobe !== 4'b0010) begin
      failures++;
      $display("FAIL abort_pulse strobe=%b exp=0010", strobe);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (strobe !== 4'b0 || busy !== 1'b0 || Sel !== 2'd0 ||
        demux_in !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset strobe=%b busy=%b sel=%0d din=%b rdy=%b exp all 0",
               strobe, busy, Sel, demux_in, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
`ifdef DEMUX_SCHED_STATS_EN
    check_cnt("after_abort");
`endif
    mode = 1'b0;
    deliver(1'b0, 1'b0, g);
    checks++;
    if (g !== 2'd0) begin
      failures++;
      $display("FAIL first_after_reset sel=%0d exp=0", g);
    end
  endtask

  task automatic test_random();
    logic [1:0] g;
    for (int i = 0; i < 40; i++) begin
      dest_ready = 4'($urandom_range(1, 15));
      mode       = 1'($urandom);
      fixed_sel  = 2'($urandom);
      if (mode && !dest_ready[fixed_sel]) dest_ready[fixed_sel] = 1'b1;
      deliver(1'($urandom), ($urandom_range(0, 3) == 0), g);
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 1'b0;
    mode       = 1'b0;
    fixed_sel  = 2'd0;
    dest_ready = 4'b0;
    model_reset();
    test_reset();
    test_rr_all();
    test_reset();
    test_rr_sparse();
    test_fixed();
    test_commit();
    test_no_dest();
    test_reset_mid_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
